// File: rtl/team_06_i2c_target_if.sv
// team_06_i2c_target_if: bus-side and consumer-side signals of the I2C write target.
// master: the bus/consumer side driving SCL, SDA and data_ready.
// slave:  the target itself.
`timescale 1ns/1ps
interface team_06_i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       oeb;
  logic [7:0] data_o;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  modport master (
    output scl_i, sda_i, data_ready,
    input  sda_o, oeb, data_o, data_valid, busy, frame_done, overrun
  );

  modport slave (
    input  scl_i, sda_i, data_ready,
    output sda_o, oeb, data_o, data_valid, busy, frame_done, overrun
  );
endinterface

// File: rtl/team_06_i2c_target.sv
// team_06_i2c_target: write-only I2C target. Bytes arrive LSB first, are
// ACKed when the output holding register is free and handed to a
// valid/ready consumer.
// Optional feature: define TEAM_06_I2C_ADDR_MATCH_EN to treat the first byte
// after every START as a 7-bit address (ADDR) plus write bit; without it every
// byte after START is data and ADDR is not used for matching.
`timescale 1ns/1ps
module team_06_i2c_target #(
  parameter logic [6:0] ADDR        = 7'h27,
  parameter int         SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  team_06_i2c_target_if.slave bus
);

  localparam int DATA_W = 8;

  // Elaboration-time parameter sanity: synchronizer depth and a non-reserved address.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("team_06_i2c_target: SYNC_STAGES must be 2 or 3");
  end
  if (ADDR < 7'h08 || ADDR > 7'h77) begin : g_bad_addr
    $error("team_06_i2c_target: ADDR lies in a reserved I2C address range");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_DATA_ACK
`ifdef TEAM_06_I2C_ADDR_MATCH_EN
    , ST_ADDR,
    ST_ADDR_ACK,
    ST_IGNORE
`endif
  } state_t;

`ifdef TEAM_06_I2C_ADDR_MATCH_EN
  localparam state_t ST_FIRST = ST_ADDR;

  // Address byte matches when the low seven bits equal ADDR and bit 7 (R/W) is write.
  function automatic logic addr_match(input logic [DATA_W-1:0] b);
    return (b[6:0] == ADDR) && (b[7] == 1'b0);
  endfunction
`else
  localparam state_t ST_FIRST = ST_DATA;
`endif

  // Synchronizer chains, last stage (p0) and one delay flop (p1).
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_p0;
  logic                   sda_p0;
  logic                   scl_p1;
  logic                   sda_p1;

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [6:0]  shreg_q;
  logic [6:0]  shreg_d;
  logic        phase_q;
  logic        phase_d;
  logic        ack_q;
  logic        ack_d;
  logic        frame_done_q;

  logic              byte_done;
  logic              byte_ok;
  logic [DATA_W-1:0] rx_byte;

  logic [DATA_W-1:0] data_q;
  logic              data_valid_q;
  logic              overrun_q;
  logic              drive_ack;

  // Bring SCL/SDA into the clk domain; reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p1   <= 1'b1;
      sda_p1   <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_p1   <= scl_p0;
      sda_p1   <= sda_p0;
    end
  end

  assign scl_p0    = scl_sync[SYNC_STAGES-1];
  assign sda_p0    = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_p0 & ~scl_p1;
  assign scl_fall  = ~scl_p0 & scl_p1;
  assign start_det = scl_p0 & scl_p1 & sda_p1 & ~sda_p0;
  assign stop_det  = scl_p0 & scl_p1 & ~sda_p1 & sda_p0;

  // The eighth bit completes the byte directly from the synchronized line.
  assign rx_byte   = {sda_p0, shreg_q};
  // A byte can be taken if the holding register is empty or is being consumed now.
  assign byte_ok   = ~data_valid_q | bus.data_ready;

  // FSM state and per-byte control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      phase_q      <= 1'b0;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      ack_q        <= ack_d;
      frame_done_q <= stop_det & (state_q != ST_IDLE);
    end
  end

  // Partial-byte shift register; always fully rewritten before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  // Next state: START/STOP override everything, then per-state bit/ACK handling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    phase_d   = phase_q;
    ack_d     = ack_q;
    byte_done = 1'b0;
    if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      phase_d = 1'b0;
      ack_d   = 1'b0;
    end else if (start_det) begin
      state_d = ST_FIRST;
      cnt_d   = 3'd0;
      phase_d = 1'b0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              byte_done = 1'b1;
              ack_d     = byte_ok;
              phase_d   = 1'b0;
              state_d   = ST_DATA_ACK;
            end else begin
              shreg_d[cnt_q] = sda_p0;
            end
          end
        end
`ifdef TEAM_06_I2C_ADDR_MATCH_EN
        ST_ADDR: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              phase_d = 1'b0;
              if (addr_match(rx_byte)) begin
                ack_d   = 1'b1;
                state_d = ST_ADDR_ACK;
              end else begin
                ack_d   = 1'b0;
                state_d = ST_IGNORE;
              end
            end else begin
              shreg_d[cnt_q] = sda_p0;
            end
          end
        end
        ST_ADDR_ACK,
`endif
        ST_DATA_ACK: begin
          // First SCL fall opens the slot, second one closes it.
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              ack_d   = 1'b0;
              state_d = ST_DATA;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Holding register toward the consumer, with sticky overrun on refused bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (byte_done && byte_ok) begin
        data_q       <= rx_byte;
        data_valid_q <= 1'b1;
      end else if (data_valid_q && bus.data_ready) begin
        data_valid_q <= 1'b0;
      end
      if (byte_done && !byte_ok) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // SDA is pulled low only inside an open slot for an accepted byte.
  assign drive_ack      = phase_q & ack_q;
  assign bus.oeb        = ~drive_ack;
  assign bus.sda_o      = ~drive_ack;
  assign bus.data_o     = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_team_06_i2c_target.sv
// tb_team_06_i2c_target: bit-banged I2C controller driving the target with
// random bytes; expectations come from a byte-level model of the protocol.
`timescale 1ns/1ps
module tb_team_06_i2c_target;
  localparam int Q = 8;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic m_scl      = 1'b1;
  logic m_sda      = 1'b1;
  logic data_ready = 1'b0;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   fd_cnt   = 0;
  int   dv_rise  = 0;
  logic dv_prev  = 1'b0;
  logic oeb_low_in_data = 1'b0;
  logic [7:0] acc_q[$];

  team_06_i2c_target_if bus();

  wire sda_line = m_sda & (bus.oeb | bus.sda_o);
  assign bus.scl_i      = m_scl;
  assign bus.sda_i      = sda_line;
  assign bus.data_ready = data_ready;

  team_06_i2c_target #(.ADDR(7'h27), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Consumer/event monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!rst && bus.data_valid && data_ready) acc_q.push_back(bus.data_o);
    if (bus.frame_done) fd_cnt++;
    if (bus.data_valid && !dv_prev) dv_rise++;
    dv_prev = bus.data_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
    wq();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wq();
    m_scl = 1'b1; wq();
    if (bus.oeb === 1'b0) oeb_low_in_data = 1'b1;
    wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic ack_slot(output logic acked);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    acked = (sda_line === 1'b0);
    wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    ack_slot(acked);
  endtask

  task automatic open_frame();
    logic a;
    bus_start();
`ifdef TEAM_06_I2C_ADDR_MATCH_EN
    send_byte(8'h27, a);
`else
    a = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.oeb !== 1'b1) $display("FAIL reset_oeb: got %b expected 1", bus.oeb); else n_pass++;
    n_checks++; if (bus.sda_o !== 1'b1) $display("FAIL reset_sda_o: got %b expected 1", bus.sda_o); else n_pass++;
    n_checks++; if (bus.data_o !== 8'h00) $display("FAIL reset_data_o: got %h expected 00", bus.data_o); else n_pass++;
    n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b expected 0", bus.data_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); else n_pass++;
    n_checks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", bus.overrun); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic a;
    int   fd0;
    data_ready = 1'b1; acc_q.delete(); oeb_low_in_data = 1'b0; fd0 = fd_cnt;
    open_frame();
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy_after_start: got %b expected 1", bus.busy); else n_pass++;
    send_byte(8'hA5, a);
    n_checks++; if (a !== 1'b1) $display("FAIL single_ack: got %b expected 1", a); else n_pass++;
    bus_stop();
    n_checks++; if (acc_q.size() != 1) $display("FAIL single_count: got %0d expected 1", acc_q.size()); else n_pass++;
    if (acc_q.size() > 0) begin
      n_checks++; if (acc_q[0] !== 8'hA5) $display("FAIL single_data: got %h expected a5", acc_q[0]); else n_pass++;
    end
    n_checks++; if (fd_cnt - fd0 != 1) $display("FAIL single_frame_done: got %0d pulses expected 1", fd_cnt - fd0); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_after_stop: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.data_o !== 8'hA5) $display("FAIL single_data_o_hold: got %h expected a5", bus.data_o); else n_pass++;
    n_checks++; if (oeb_low_in_data !== 1'b0) $display("FAIL single_oeb_in_data: got %b expected 0", oeb_low_in_data); else n_pass++;
  endtask

  task automatic test_random_frames();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       a;
    int         fd0;
    int         nb;
    data_ready = 1'b1; acc_q.delete(); oeb_low_in_data = 1'b0; fd0 = fd_cnt;
    for (int f = 0; f < 5; f++) begin
      open_frame();
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        send_byte(b, a);
        exp_q.push_back(b);
        n_checks++; if (a !== 1'b1) $display("FAIL rand_ack: byte %h got %b expected 1", b, a); else n_pass++;
      end
      bus_stop();
    end
    n_checks++; if (acc_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", acc_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
      n_checks++; if (acc_q[k] !== exp_q[k]) $display("FAIL rand_data[%0d]: got %h expected %h", k, acc_q[k], exp_q[k]); else n_pass++;
    end
    n_checks++; if (fd_cnt - fd0 != 5) $display("FAIL rand_frame_done: got %0d expected 5", fd_cnt - fd0); else n_pass++;
    n_checks++; if (oeb_low_in_data !== 1'b0) $display("FAIL rand_oeb_in_data: got %b expected 0", oeb_low_in_data); else n_pass++;
  endtask

  task automatic test_overrun();
    logic       a1;
    logic       a2;
    logic       a;
    logic [7:0] b;
    int         nx;
    do_reset();
    data_ready = 1'b0;
    open_frame();
    send_byte(8'h11, a1);
    send_byte(8'h22, a2);
    nx = $urandom_range(1, 2);
    for (int k = 0; k < nx; k++) begin
      b = 8'($urandom);
      send_byte(b, a);
      n_checks++; if (a !== 1'b0) $display("FAIL ovr_extra_nack: byte %h got ack %b expected 0", b, a); else n_pass++;
    end
    bus_stop();
    n_checks++; if (a1 !== 1'b1) $display("FAIL ovr_first_ack: got %b expected 1", a1); else n_pass++;
    n_checks++; if (a2 !== 1'b0) $display("FAIL ovr_second_nack: got %b expected 0", a2); else n_pass++;
    n_checks++; if (bus.data_o !== 8'h11) $display("FAIL ovr_data_o: got %h expected 11", bus.data_o); else n_pass++;
    n_checks++; if (bus.data_valid !== 1'b1) $display("FAIL ovr_data_valid: got %b expected 1", bus.data_valid); else n_pass++;
    n_checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_overrun: got %b expected 1", bus.overrun); else n_pass++;
    @(negedge clk); data_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL ovr_drain: got %b expected 0", bus.data_valid); else n_pass++;
    n_checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", bus.overrun); else n_pass++;
    do_reset();
    n_checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr_reset_clears: got %b expected 0", bus.overrun); else n_pass++;
    acc_q.delete();
  endtask

  task automatic test_simultaneous();
    logic [7:0] ba;
    logic [7:0] bb;
    logic       a;
    do_reset();
    data_ready = 1'b0;
    ba = 8'($urandom);
    bb = 8'($urandom);
    open_frame();
    send_byte(ba, a);
    for (int i = 0; i < 7; i++) send_bit(bb[i]);
    // Consumer takes the pending byte on exactly the clk the eighth bit lands.
    m_sda = bb[7]; wq();
    m_scl = 1'b1;
    @(negedge clk);
    @(negedge clk); data_ready = 1'b1;
    @(negedge clk); data_ready = 1'b0;
    repeat (2 * Q - 3) @(negedge clk);
    m_scl = 1'b0; wq();
    ack_slot(a);
    n_checks++; if (a !== 1'b1) $display("FAIL simul_ack: got %b expected 1", a); else n_pass++;
    n_checks++; if (bus.data_o !== bb) $display("FAIL simul_data_o: got %h expected %h", bus.data_o, bb); else n_pass++;
    n_checks++; if (bus.data_valid !== 1'b1) $display("FAIL simul_data_valid: got %b expected 1", bus.data_valid); else n_pass++;
    n_checks++; if (bus.overrun !== 1'b0) $display("FAIL simul_overrun: got %b expected 0", bus.overrun); else n_pass++;
    bus_stop();
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    acc_q.delete();
  endtask

  task automatic test_stop_mid_byte();
    int dv0;
    int fd0;
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    dv0 = dv_rise; fd0 = fd_cnt;
    open_frame();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    bus_stop();
    n_checks++; if (dv_rise != dv0) $display("FAIL midstop_data_valid: got %0d sets expected 0", dv_rise - dv0); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midstop_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (fd_cnt - fd0 != 1) $display("FAIL midstop_frame_done: got %0d clks expected 1", fd_cnt - fd0); else n_pass++;
    n_checks++; if (bus.oeb !== 1'b1) $display("FAIL midstop_oeb: got %b expected 1", bus.oeb); else n_pass++;
  endtask

  task automatic test_repeated_start();
    logic [7:0] b;
    logic       a;
    int         fd0;
    data_ready = 1'b1; acc_q.delete(); fd0 = fd_cnt;
    b = 8'($urandom);
    open_frame();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    open_frame();
    send_byte(b, a);
    bus_stop();
    n_checks++; if (a !== 1'b1) $display("FAIL rstart_ack: got %b expected 1", a); else n_pass++;
    n_checks++; if (acc_q.size() != 1) $display("FAIL rstart_count: got %0d expected 1", acc_q.size()); else n_pass++;
    if (acc_q.size() > 0) begin
      n_checks++; if (acc_q[0] !== b) $display("FAIL rstart_data: got %h expected %h", acc_q[0], b); else n_pass++;
    end
    n_checks++; if (fd_cnt - fd0 != 1) $display("FAIL rstart_frame_done: got %0d expected 1", fd_cnt - fd0); else n_pass++;
  endtask

  task automatic test_reset_in_ack();
    logic [7:0] b;
    logic       a;
    int         dv0;
    int         fd0;
    data_ready = 1'b1;
    b = 8'($urandom);
    open_frame();
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    n_checks++; if (bus.oeb !== 1'b0) $display("FAIL rstack_slot_driven: got oeb %b expected 0", bus.oeb); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.oeb !== 1'b1) $display("FAIL rstack_oeb: got %b expected 1", bus.oeb); else n_pass++;
    n_checks++; if (bus.sda_o !== 1'b1) $display("FAIL rstack_sda_o: got %b expected 1", bus.sda_o); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstack_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL rstack_data_valid: got %b expected 0", bus.data_valid); else n_pass++;
    n_checks++; if (bus.data_o !== 8'h00) $display("FAIL rstack_data_o: got %h expected 00", bus.data_o); else n_pass++;
    rst = 1'b0;
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
    dv0 = dv_rise; fd0 = fd_cnt; oeb_low_in_data = 1'b0;
    send_byte(8'($urandom), a);
    bus_stop();
    n_checks++; if (a !== 1'b0) $display("FAIL rstack_ignored_ack: got %b expected 0", a); else n_pass++;
    n_checks++; if (dv_rise != dv0) $display("FAIL rstack_ignored_data: got %0d sets expected 0", dv_rise - dv0); else n_pass++;
    n_checks++; if (fd_cnt != fd0) $display("FAIL rstack_idle_stop: got %0d pulses expected 0", fd_cnt - fd0); else n_pass++;
    n_checks++; if (oeb_low_in_data !== 1'b0) $display("FAIL rstack_oeb_in_data: got %b expected 0", oeb_low_in_data); else n_pass++;
    acc_q.delete();
  endtask

`ifdef TEAM_06_I2C_ADDR_MATCH_EN
  task automatic test_addr_match();
    logic a1;
    logic a2;
    logic a3;
    logic a4;
    int   dv0;
    data_ready = 1'b1; acc_q.delete();
    bus_start();
    send_byte(8'h27, a1);
    send_byte(8'h3C, a2);
    bus_stop();
    n_checks++; if (a1 !== 1'b1) $display("FAIL addr_ack: got %b expected 1", a1); else n_pass++;
    n_checks++; if (a2 !== 1'b1) $display("FAIL addr_data_ack: got %b expected 1", a2); else n_pass++;
    n_checks++; if (bus.data_o !== 8'h3C) $display("FAIL addr_data_o: got %h expected 3c", bus.data_o); else n_pass++;
    dv0 = dv_rise;
    bus_start();
    send_byte(8'h26, a3);
    send_byte(8'($urandom), a4);
    bus_stop();
    n_checks++; if (a3 !== 1'b0) $display("FAIL addr_mismatch_nack: got %b expected 0", a3); else n_pass++;
    n_checks++; if (a4 !== 1'b0) $display("FAIL addr_ignore_nack: got %b expected 0", a4); else n_pass++;
    n_checks++; if (dv_rise != dv0) $display("FAIL addr_ignore_data: got %0d sets expected 0", dv_rise - dv0); else n_pass++;
    acc_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_random_frames();
    test_overrun();
    test_simultaneous();
    test_stop_mid_byte();
    test_repeated_start();
    test_reset_in_ack();
`ifdef TEAM_06_I2C_ADDR_MATCH_EN
    test_addr_match();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/team_06_i2c_target.md
TEAM_06_I2C_TARGET -- requirements
Module: team_06_i2c_target

Interface
REQ-001: Parameter ADDR, default 7'h27, 7-bit target address used when address match is compiled in.
REQ-002: Parameter SYNC_STAGES, default 2, synchronizer depth on scl_i/sda_i; legal range 2..3.
REQ-003: clk  input  1  system clock; single clock domain.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: scl_i  input  1  I2C clock from the bus, asynchronous to clk.
REQ-006: sda_i  input  1  I2C data from the bus, asynchronous to clk.
REQ-007: sda_o  output  1  data driven onto SDA when oeb=0.
REQ-008: oeb  output  1  SDA output enable, active-low; 1 = released/input.
REQ-009: data_o  output  8  last received data byte.
REQ-010: data_valid  output  1  data_o holds an unconsumed byte.
REQ-011: data_ready  input  1  consumer accepts data_o when data_valid && data_ready.
REQ-012: busy  output  1  high between detected START and STOP.
REQ-013: frame_done  output  1  one-clk pulse on detected STOP.
REQ-014: overrun  output  1  sticky; a byte arrived while data_valid was still high.

Function
REQ-015: scl_i/sda_i SHALL pass through SYNC_STAGES flops; all edge/condition detection uses synchronized values plus one delay flop.
REQ-016: START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be detected in every state.
REQ-017: States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-018: IDLE->ADDR on START when address match compiled in, IDLE->DATA otherwise; busy=1 from the clk after START.
REQ-019: Bits SHALL be sampled on SCL rising edge, LSB first (bit 0 first), matching team_06_i2c; 3-bit bit counter wraps 7->0.
REQ-020: After 8th bit in ADDR: bits[6:0]==ADDR and bit 7==0 (write) -> ADDR_ACK; otherwise -> IGNORE, no ACK.
REQ-021: After 8th bit in DATA: byte SHALL be ACKed if data_valid==0 (or is accepted this same clk), NACKed otherwise; -> DATA_ACK.
REQ-022: ACK drive: on the SCL falling edge after the 8th rising edge, sda_o=0, oeb=0; released (sda_o=1, oeb=1) on the next SCL falling edge, then return to DATA.
REQ-023: NACK: oeb stays 1 through the ACK slot; state still returns to DATA.
REQ-024: On ACKed byte, data_o loads the byte and data_valid sets in the clk of the 8th sampled rising edge; latency 1 clk after synchronized edge.
REQ-025: data_valid clears the clk after data_valid && data_ready; simultaneous new byte and acceptance SHALL load new byte, data_valid stays 1, no overrun.
REQ-026: NACKed byte SHALL set overrun, leave data_o unchanged; overrun clears only on rst.
REQ-027: Repeated START mid-byte or in any state SHALL discard partial bits, reset bit counter, re-enter ADDR/DATA per REQ-018.
REQ-028: STOP in any non-IDLE state SHALL discard partial bits, release SDA, -> IDLE, busy=0, frame_done pulse one clk.
REQ-029: IGNORE SHALL keep oeb=1 until START or STOP.
REQ-030: oeb SHALL be 0 only during an ACK slot.

Reset
REQ-031: On rst: state=IDLE, sda_o=1, oeb=1, data_o=8'h00, data_valid=0, busy=0, frame_done=0, overrun=0, bit counter=0, synchronizers=1.
REQ-032: rst mid-transfer SHALL release SDA the following clk; the target ignores the bus until the next START.

Configuration
REQ-033: Macro TEAM_06_I2C_ADDR_MATCH_EN: defined -> first byte after START is the address per REQ-020; undefined -> ADDR/ADDR_ACK removed, every byte after START is data, ADDR unused.

Verification
REQ-034: Macro undefined; START, byte 8'hA5 LSB-first, STOP, data_ready=1 -> ACK low in slot, data_valid pulse with data_o=8'hA5, frame_done pulse, busy low.
REQ-035: Macro defined, ADDR=7'h27; address byte 8'h27 then 8'h3C -> both ACKed, data_o=8'h3C; address 8'h26 -> no ACK, data_valid never set.
REQ-036: data_ready=0; bytes 8'h11 then 8'h22 -> first ACKed, second NACKed, data_o=8'h11, overrun=1.
REQ-037: STOP after 4 bits of a byte -> data_valid stays 0, state IDLE, frame_done=1 one clk, oeb=1.
REQ-038: rst asserted during ACK slot -> next clk oeb=1, sda_o=1, all outputs at reset values.
REQ-039: Loopback with team_06_i2c sending 8'h5A -> data_o=8'h5A, data_valid=1.
